pipe_reg_chain: RTL and testbench

//  Parametrised, flow-controlled pipeline register: DEPTH cascaded skid-buffer stages carrying a

---
 rtl/pipe_reg_chain_pkg.sv | 7 +
 rtl/pipe_skid_stage.sv | 64 ++++++
 rtl/pipe_reg_chain.sv | 49 ++++
 tb/tb_pipe_reg_chain.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_reg_chain_pkg.sv
// pipe_pkg: shared stage state encoding and occupancy width helper
package pipe_pkg;
  typedef enum logic [1:0] {ST_EMPTY = 2'd0, ST_BUSY = 2'd1, ST_FULL = 2'd2} stage_state_t;
  function automatic int occ_w(input int depth);
    return $clog2(2 * depth + 1);
  endfunction
endpackage

// File: rtl/pipe_skid_stage.sv
// pipe_skid_stage: one skid-buffer stage with ready derived from state only, plus flush
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);
  stage_state_t state, state_nx;
  logic [WIDTH-1:0] main, skid;
  logic accept, pop, load_main, load_skid;
  assign in_ready  = state != ST_FULL;
  assign out_valid = state != ST_EMPTY;
  assign out_data  = main;
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  always_comb begin
    state_nx  = state;
    load_main = 1'b0;
    load_skid = 1'b0;
    case (state)
      ST_EMPTY: begin
        load_main = accept;
        state_nx  = accept ? ST_BUSY : ST_EMPTY;
      end
      ST_BUSY: begin
        load_main = accept & pop;
        load_skid = accept & ~pop;
        state_nx  = (accept & ~pop) ? ST_FULL : (~accept & pop) ? ST_EMPTY : ST_BUSY;
      end
      ST_FULL: begin
        load_main = pop;
        state_nx  = pop ? ST_BUSY : ST_FULL;
      end
      default: state_nx = ST_EMPTY;
    endcase
    // flush empties the stage but leaves the data registers untouched
    if (flush) begin
      state_nx  = ST_EMPTY;
      load_main = 1'b0;
      load_skid = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_EMPTY;
      main  <= RESET_VAL;
      skid  <= RESET_VAL;
    end else begin
      state <= state_nx;
      if (load_main) main <= (state == ST_FULL) ? skid : in_data;
      if (load_skid) skid <= in_data;
    end
  end
endmodule

// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain: DEPTH cascaded skid stages under valid/ready with flush and occupancy count
module pipe_reg_chain
  import pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WIDTH-1:0]               in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [WIDTH-1:0]               out_data,
  output logic [$clog2(2*DEPTH+1)-1:0]   occupancy
);
  localparam int OW = occ_w(DEPTH);
  logic [DEPTH:0] v, r;
  logic [WIDTH-1:0] d [DEPTH+1];
  assign v[0]      = in_valid;
  assign d[0]      = in_data;
  assign in_ready  = r[0];
  assign out_valid = v[DEPTH];
  assign out_data  = d[DEPTH];
  assign r[DEPTH]  = out_ready;
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    pipe_skid_stage #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_stage (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (v[k]),
      .in_ready  (r[k]),
      .in_data   (d[k]),
      .out_valid (v[k+1]),
      .out_ready (r[k+1]),
      .out_data  (d[k+1])
    );
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) occupancy <= '0;
    else if (flush) occupancy <= '0;
    else occupancy <= occupancy + OW'(in_valid & in_ready) - OW'(out_valid & out_ready);
  end
  a_occ_max: assert property (@(posedge clk) disable iff (reset) occupancy <= OW'(2 * DEPTH));
  a_valid_occ: assert property (@(posedge clk) disable iff (reset) out_valid |-> occupancy != '0);
endmodule

// File: tb/tb_pipe_reg_chain.sv
// tb_pipe_reg_chain: per-stage queue model plus end-to-end scoreboard, directed and random traffic
module tb_pipe_reg_chain;
  localparam int W = 8;
  localparam int D = 2;
  localparam logic [W-1:0] RV = 8'h5A;
  logic clk = 1'b0, reset = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid;
  logic [W-1:0] in_data = '0, out_data;
  logic [$clog2(2*D+1)-1:0] occupancy;
  pipe_reg_chain #(.WIDTH(W), .DEPTH(D), .RESET_VAL(RV)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
  );
  always #5 clk = ~clk;
  int checks = 0, errors = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  // model: each stage is a 2-slot queue; a beat moves when its stage holds one and the next has room
  int cnt[D];
  logic [W-1:0] m[D][2];
  logic [W-1:0] f[D];
  logic mv[D];
  logic inf, outf;
  logic [W-1:0] sq[$];
  logic [W-1:0] pq[$];
  int pc[$];
  int cyc = 0, acc = 0, max_occ = 0, tot;
  always @(posedge clk) cyc++;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < D; k++) cnt[k] = 0;
      sq.delete();
    end else begin
      inf  = in_valid && cnt[0] < 2;
      outf = out_ready && cnt[D-1] > 0;
      for (int k = 0; k < D; k++) f[k] = m[k][0];
      for (int k = 0; k < D - 1; k++) mv[k] = cnt[k] > 0 && cnt[k+1] < 2;
      mv[D-1] = outf;
      if (outf && sq.size() != 0) void'(sq.pop_front());
      if (inf) begin
        acc++;
        sq.push_back(in_data);
      end
      if (flush) begin
        for (int k = 0; k < D; k++) cnt[k] = 0;
        sq.delete();
      end else begin
        for (int k = 0; k < D; k++)
          if (mv[k]) begin
            m[k][0] = m[k][1];
            cnt[k]--;
          end
        for (int k = 0; k < D; k++)
          if (k == 0 ? inf : mv[k-1]) begin
            m[k][cnt[k]] = (k == 0) ? in_data : f[k-1];
            cnt[k]++;
          end
      end
    end
  end
  always @(negedge clk) begin
    if (!reset) begin
      tot = 0;
      for (int k = 0; k < D; k++) tot += cnt[k];
      chk("in_ready", in_ready, cnt[0] < 2);
      chk("out_valid", out_valid, cnt[D-1] > 0);
      if (cnt[D-1] > 0) chk("out_data", out_data, m[D-1][0]);
      chk("occupancy", occupancy, tot);
      if (out_valid && out_ready) begin
        chk("scoreboard", out_data, sq.size() != 0 ? sq[0] : 'x);
        pq.push_back(out_data);
        pc.push_back(cyc);
      end
      if (occupancy > max_occ) max_occ = occupancy;
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    #1_500_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int nxt, n, acc0;
    logic took;
    tick;
    tick;
    reset = 1'b0;
    // back-to-back stream
    out_ready = 1'b1;
    pq.delete();
    pc.delete();
    max_occ = 0;
    for (int i = 1; i <= 16; i++) begin
      in_valid = 1'b1;
      in_data  = W'(i);
      tick;
      if (i == 1) chk("lat_edge1_valid", out_valid, 0);
      if (i == 2) begin
        chk("lat_edge2_valid", out_valid, 1);
        chk("lat_edge2_data", out_data, 1);
      end
    end
    in_valid = 1'b0;
    repeat (4) tick;
    chk("stream_count", pq.size(), 16);
    for (int i = 0; i < 16 && i < pq.size(); i++) chk("stream_order", pq[i], i + 1);
    if (pc.size() == 16) chk("stream_no_bubbles", pc[15] - pc[0], 15);
    chk("stream_max_occ", max_occ <= 2, 1);
    // asynchronous reset mid-cycle with beats held
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = W'(8'h30 + i);
      tick;
    end
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, RV);
    chk("rst_occupancy", occupancy, 0);
    tick;
    reset = 1'b0;
    // backpressure
    pq.delete();
    nxt = 1;
    repeat (8) begin
      in_valid = 1'b1;
      in_data  = W'(nxt);
      took     = in_ready;
      tick;
      if (took) nxt++;
    end
    chk("bp_accepted", nxt - 1, 4);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_occupancy", occupancy, 4);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick;
    chk("bp_ready_pop1", in_ready, 0);
    tick;
    chk("bp_ready_pop2", in_ready, 1);
    repeat (4) tick;
    chk("bp_count", pq.size(), 4);
    for (int i = 0; i < 4 && i < pq.size(); i++) chk("bp_order", pq[i], i + 1);
    // flush with coincident input and output transfers
    pq.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = W'(8'h41 + i);
      tick;
    end
    chk("fl_pre_occ", occupancy, 3);
    chk("fl_pre_out_valid", out_valid, 1);
    chk("fl_pre_in_ready", in_ready, 1);
    flush     = 1'b1;
    out_ready = 1'b1;
    in_data   = 8'h77;
    tick;
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_occ", occupancy, 0);
    chk("fl_out_valid", out_valid, 0);
    chk("fl_in_ready", in_ready, 1);
    repeat (3) tick;
    chk("fl_pops", pq.size(), 1);
    if (pq.size() != 0) chk("fl_pop_data", pq[0], 8'h41);
    // reset pulse with a full chain
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = W'(8'h50 + i);
      tick;
    end
    in_valid = 1'b0;
    chk("rm_full_occ", occupancy, 4);
    #1 reset = 1'b1;
    #2 reset = 1'b0;
    chk("rm_in_ready", in_ready, 1);
    pq.delete();
    in_valid  = 1'b1;
    in_data   = 8'hAA;
    out_ready = 1'b1;
    tick;
    in_valid = 1'b0;
    chk("rm_lat_edge1", out_valid, 0);
    tick;
    chk("rm_lat_edge2_valid", out_valid, 1);
    chk("rm_lat_edge2_data", out_data, 8'hAA);
    repeat (3) tick;
    chk("rm_pops", pq.size(), 1);
    if (pq.size() != 0) chk("rm_pop_data", pq[0], 8'hAA);
    // random valid/ready traffic
    pq.delete();
    pc.delete();
    acc0 = acc;
    n = 0;
    while (acc - acc0 < 10000 && n < 60000) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = W'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      tick;
      n++;
    end
    chk("rand_reached_target", acc - acc0 >= 10000, 1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (occupancy != 0 && n < 50) begin
      tick;
      n++;
    end
    tick;
    chk("rand_drained", occupancy, 0);
    chk("rand_beats_out", pq.size(), acc - acc0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
